// File: rtl/count_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : count_mon_pkg
// Purpose  : Shared types and constants for the count_monitor checker.
//            Event type encoding, monitor FSM states, counter width and the
//            packed FIFO entry layout {type, obs, exp}.
// Config   : none (COUNT_MON_STATS_EN is consumed by count_monitor only)
// Revision : 1.0 - initial release
// ============================================================================
package count_mon_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        EVT_WRAP = 2'd0,
        EVT_LOAD = 2'd1,
        EVT_ERR  = 2'd2
    } evt_type_e;

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        CHECK = 1'b1
    } mon_state_e;

    typedef struct packed {
        evt_type_e          typ;
        logic [CNT_W-1:0]   obs;
        logic [CNT_W-1:0]   expv;
    } evt_entry_t;

    localparam int ENTRY_W = $bits(evt_entry_t);

endpackage
`default_nettype wire

// File: rtl/count_mon_fifo.sv
`default_nettype none
// ============================================================================
// Module   : count_mon_fifo
// Purpose  : Small synchronous FIFO holding classified monitor events.
//            Pointers carry one extra wrap bit so full/empty need no counter.
//            A push while full is accepted only when a pop frees the slot in
//            the same cycle; otherwise it is ignored (caller flags overflow).
//            rdata reads zero while empty.
// Ports    : clk, reset_l (async, active-low), push, pop, wdata,
//            rdata, full, empty
// Params   : DEPTH (power of two, >= 2), WIDTH (entry width)
// Revision : 1.0 - initial release
// ============================================================================
module count_mon_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = pop && !empty;
    // When full, the slot being written is the head being popped this cycle;
    // the head is read before the edge, so both may proceed together.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage is not reset; stale contents are masked by the empty flag.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : count_monitor
// Purpose  : Checker downstream of an 8-bit loadable counter. Predicts the
//            next counter value from load/in_data/out_data, classifies each
//            cycle as WRAP, LOAD, ERR or nothing, and queues events in a FIFO
//            drained over a valid/ready stream.
// Ports    : clk, reset_l (async, active-low)
//            mon_count, mon_load, mon_load_data  - snooped counter signals
//            evt_valid, evt_ready, evt_type, evt_obs, evt_exp - event stream
//            ovf (sticky drop flag), ovf_clr (sync clear)
//            wrap_cnt, err_cnt - only with COUNT_MON_STATS_EN defined
// Params   : FIFO_DEPTH (power of two, >= 2), EMIT_LOAD (1 = report loads)
// Config   : `define COUNT_MON_STATS_EN adds saturating WRAP/ERR counters
// Revision : 1.0 - initial release
// ============================================================================
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit EMIT_LOAD  = 1'b1
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [CNT_W-1:0] mon_count,
    input  logic             mon_load,
    input  logic [CNT_W-1:0] mon_load_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_type,
    output logic [CNT_W-1:0] evt_obs,
    output logic [CNT_W-1:0] evt_exp,
    output logic             ovf,
    input  logic             ovf_clr
`ifdef COUNT_MON_STATS_EN
    ,
    output logic [15:0]      wrap_cnt,
    output logic [15:0]      err_cnt
`endif
);

    mon_state_e       r_state;
    logic [CNT_W-1:0] r_pred;
    logic             r_load_d;
    logic             r_ovf;

    logic             w_evt_gen;
    evt_type_e        w_evt_typ;
    evt_entry_t       w_push_entry;
    evt_entry_t       w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic [CNT_W-1:0] w_next_pred;

    // ------------------------------------------------------------------
    // Predictor: what the counter must show next cycle.
    // ------------------------------------------------------------------
    assign w_next_pred = mon_load ? mon_load_data : (mon_count + 8'd1);

    // ------------------------------------------------------------------
    // Monitor FSM. SYNC exists so the first cycle after reset only seeds
    // the prediction; there is no valid previous value to compare with.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state  <= SYNC;
            r_pred   <= '0;
            r_load_d <= 1'b0;
        end else begin
            r_pred   <= w_next_pred;
            r_load_d <= mon_load;
            case (r_state)
                SYNC:    r_state <= CHECK;
                CHECK:   r_state <= CHECK;
                default: r_state <= SYNC;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Classifier. A mismatch always wins; a matched load suppresses the
    // wrap check, so loading 0x00 over 0xFF is reported as LOAD only.
    // ------------------------------------------------------------------
    always_comb begin
        w_evt_gen = 1'b0;
        w_evt_typ = EVT_WRAP;
        if (r_state == CHECK) begin
            if (mon_count != r_pred) begin
                w_evt_gen = 1'b1;
                w_evt_typ = EVT_ERR;
            end else if (r_load_d) begin
                w_evt_gen = EMIT_LOAD;
                w_evt_typ = EVT_LOAD;
            end else if (mon_count == '0) begin
                w_evt_gen = 1'b1;
                w_evt_typ = EVT_WRAP;
            end
        end
    end

    assign w_push_entry.typ  = w_evt_typ;
    assign w_push_entry.obs  = mon_count;
    assign w_push_entry.expv = r_pred;

    // ------------------------------------------------------------------
    // Event queue
    // ------------------------------------------------------------------
    assign w_pop = !w_empty && evt_ready;

    count_mon_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .push    (w_evt_gen),
        .pop     (w_pop),
        .wdata   (w_push_entry),
        .rdata   (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign evt_valid = !w_empty;
    assign evt_type  = w_head.typ;
    assign evt_obs   = w_head.obs;
    assign evt_exp   = w_head.expv;

    // ------------------------------------------------------------------
    // Sticky overflow: a drop in the same cycle as a clear keeps the flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_ovf <= 1'b0;
        end else if (w_evt_gen && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;

`ifdef COUNT_MON_STATS_EN
    // ------------------------------------------------------------------
    // Saturating event counters. Dropped events still count. An event in
    // the same cycle as a clear is kept, leaving the counter at 1.
    // ------------------------------------------------------------------
    logic [15:0] r_wrap_cnt;
    logic [15:0] r_err_cnt;
    logic        w_is_wrap;
    logic        w_is_err;

    assign w_is_wrap = w_evt_gen && (w_evt_typ == EVT_WRAP);
    assign w_is_err  = w_evt_gen && (w_evt_typ == EVT_ERR);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_wrap_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (ovf_clr) begin
            r_wrap_cnt <= {15'd0, w_is_wrap};
            r_err_cnt  <= {15'd0, w_is_err};
        end else begin
            if (w_is_wrap && (r_wrap_cnt != 16'hFFFF)) r_wrap_cnt <= r_wrap_cnt + 16'd1;
            if (w_is_err  && (r_err_cnt  != 16'hFFFF)) r_err_cnt  <= r_err_cnt  + 16'd1;
        end
    end

    assign wrap_cnt = r_wrap_cnt;
    assign err_cnt  = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_monitor
// Purpose  : Directed self-checking bench for count_monitor. A second
//            instance with EMIT_LOAD=0 shares all inputs so load suppression
//            can be compared against the reporting instance.
// Config   : COUNT_MON_STATS_EN (optional) enables the counter checks
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       reset_l = 1'b0;
    logic [7:0] mon_count = 8'h00;
    logic       mon_load = 1'b0;
    logic [7:0] mon_load_data = 8'h00;
    logic       evt_ready = 1'b0;
    logic       ovf_clr = 1'b0;

    logic       evt_valid, ovf;
    logic [1:0] evt_type;
    logic [7:0] evt_obs, evt_exp;
    logic       evt_valid2, ovf2;
    logic [1:0] evt_type2;
    logic [7:0] evt_obs2, evt_exp2;

    logic [18:0] head, head2;
    assign head  = {evt_valid,  evt_type,  evt_obs,  evt_exp};
    assign head2 = {evt_valid2, evt_type2, evt_obs2, evt_exp2};

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] cnt;

`ifdef COUNT_MON_STATS_EN
    logic [15:0] wrap_cnt, err_cnt, wrap_cnt2, err_cnt2;
`endif

    always #5 clk = ~clk;

    count_monitor #(.FIFO_DEPTH(4), .EMIT_LOAD(1'b1)) dut (
        .clk(clk), .reset_l(reset_l),
        .mon_count(mon_count), .mon_load(mon_load), .mon_load_data(mon_load_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
        .evt_obs(evt_obs), .evt_exp(evt_exp), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef COUNT_MON_STATS_EN
        , .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
`endif
    );

    count_monitor #(.FIFO_DEPTH(4), .EMIT_LOAD(1'b0)) dut_noload (
        .clk(clk), .reset_l(reset_l),
        .mon_count(mon_count), .mon_load(mon_load), .mon_load_data(mon_load_data),
        .evt_valid(evt_valid2), .evt_ready(evt_ready), .evt_type(evt_type2),
        .evt_obs(evt_obs2), .evt_exp(evt_exp2), .ovf(ovf2), .ovf_clr(ovf_clr)
`ifdef COUNT_MON_STATS_EN
        , .wrap_cnt(wrap_cnt2), .err_cnt(err_cnt2)
`endif
    );

    // One counter cycle: drive snooped inputs, let one edge consume them,
    // then step 1 time unit past the edge for sampling.
    task automatic cyc(input logic [7:0] c, input logic ld, input logic [7:0] ld_data);
        mon_count     = c;
        mon_load      = ld;
        mon_load_data = ld_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_l = 1'b0;
        cyc(8'h00, 1'b0, 8'h00);
        cyc(8'h00, 1'b0, 8'h00);
        n_checks++;
        if (head !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_head: got=%h want=%h", head, 19'h0);
        end
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got=%b want=0", ovf);
        end
`ifdef COUNT_MON_STATS_EN
        n_checks++;
        if ({wrap_cnt, err_cnt} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_stats: got=%h want=0", {wrap_cnt, err_cnt});
        end
`endif
        reset_l = 1'b1;
    endtask

    task automatic test_free_run;
        evt_ready = 1'b1;
        for (int v = 0; v <= 5; v++) begin
            cyc(8'(v), 1'b0, 8'h00);
            n_checks++;
            if (evt_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL free_run_valid v=%0d: got=%b want=0", v, evt_valid);
            end
        end
        for (int v = 6; v <= 253; v++) cyc(8'(v), 1'b0, 8'h00);
    endtask

    task automatic test_wrap;
        cyc(8'hFE, 1'b0, 8'h00);
        cyc(8'hFF, 1'b0, 8'h00);
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_pre_valid: got=%b want=0", evt_valid);
        end
        cyc(8'h00, 1'b0, 8'h00);
        n_checks++;
        if (head !== {1'b1, 2'd0, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL wrap_event: got=%h want=%h", head, {1'b1, 2'd0, 8'h00, 8'h00});
        end
        cyc(8'h01, 1'b0, 8'h00);
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_popped: got=%b want=0", evt_valid);
        end
    endtask

    task automatic test_load;
        for (int v = 2; v <= 15; v++) cyc(8'(v), 1'b0, 8'h00);
        cyc(8'h10, 1'b1, 8'hA5);
        cyc(8'hA5, 1'b0, 8'h00);
        n_checks++;
        if (head !== {1'b1, 2'd1, 8'hA5, 8'hA5}) begin
            n_fail++;
            $display("FAIL load_event: got=%h want=%h", head, {1'b1, 2'd1, 8'hA5, 8'hA5});
        end
        n_checks++;
        if (evt_valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL load_suppressed: got=%b want=0", evt_valid2);
        end
        cyc(8'hA6, 1'b1, 8'hFE);
        cyc(8'hFE, 1'b0, 8'h00);
        n_checks++;
        if (head !== {1'b1, 2'd1, 8'hFE, 8'hFE}) begin
            n_fail++;
            $display("FAIL load_fe_event: got=%h want=%h", head, {1'b1, 2'd1, 8'hFE, 8'hFE});
        end
        // 0xFF with a load of 0x00: the following 0x00 is a LOAD, not a WRAP
        cyc(8'hFF, 1'b1, 8'h00);
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ff_quiet: got=%b want=0", evt_valid);
        end
        cyc(8'h00, 1'b0, 8'h00);
        n_checks++;
        if (head !== {1'b1, 2'd1, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL load_zero_not_wrap: got=%h want=%h", head, {1'b1, 2'd1, 8'h00, 8'h00});
        end
        n_checks++;
        if (evt_valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL load_zero_noload_quiet: got=%b want=0", evt_valid2);
        end
        cyc(8'h01, 1'b0, 8'h00);
    endtask

    task automatic test_err;
        for (int v = 2; v <= 32; v++) cyc(8'(v), 1'b0, 8'h00);
        cyc(8'h30, 1'b0, 8'h00);
        n_checks++;
        if (head !== {1'b1, 2'd2, 8'h30, 8'h21}) begin
            n_fail++;
            $display("FAIL err_event: got=%h want=%h", head, {1'b1, 2'd2, 8'h30, 8'h21});
        end
        n_checks++;
        if (head2 !== {1'b1, 2'd2, 8'h30, 8'h21}) begin
            n_fail++;
            $display("FAIL err_event_noload: got=%h want=%h", head2, {1'b1, 2'd2, 8'h30, 8'h21});
        end
`ifdef COUNT_MON_STATS_EN
        n_checks++;
        if (err_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL err_cnt_one: got=%0d want=1", err_cnt);
        end
`endif
        cyc(8'h31, 1'b0, 8'h00);
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_popped: got=%b want=0", evt_valid);
        end
    endtask

    task automatic test_overflow;
        logic [18:0] exp_q [4];
        int wraps;
        exp_q[0] = {1'b1, 2'd2, 8'h40, 8'h32};
        exp_q[1] = {1'b1, 2'd0, 8'h00, 8'h00};
        exp_q[2] = {1'b1, 2'd0, 8'h00, 8'h00};
        exp_q[3] = {1'b1, 2'd0, 8'h00, 8'h00};
        evt_ready = 1'b0;
        cyc(8'h40, 1'b0, 8'h00);
        cnt = 8'h41;
        wraps = 0;
        // ERR then four WRAPs: the fourth WRAP is the fifth event and drops
        for (int k = 0; k < 2000 && wraps < 4; k++) begin
            cyc(cnt, 1'b0, 8'h00);
            if (cnt == 8'h00) wraps++;
            cnt = cnt + 8'd1;
        end
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got=%b want=1", ovf);
        end
`ifdef COUNT_MON_STATS_EN
        n_checks++;
        if ({wrap_cnt, err_cnt} !== {16'd5, 16'd2}) begin
            n_fail++;
            $display("FAIL stats_before_clr: got=%h want=%h", {wrap_cnt, err_cnt}, {16'd5, 16'd2});
        end
`endif
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (head !== exp_q[i]) begin
                n_fail++;
                $display("FAIL drain_entry%0d: got=%h want=%h", i, head, exp_q[i]);
            end
            cyc(cnt, 1'b0, 8'h00);
            cnt = cnt + 8'd1;
        end
        n_checks++;
        if ({evt_valid, ovf} !== 2'b01) begin
            n_fail++;
            $display("FAIL drain_empty_ovf_held: got=%b want=01", {evt_valid, ovf});
        end
        ovf_clr = 1'b1;
        cyc(cnt, 1'b0, 8'h00);
        cnt = cnt + 8'd1;
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_cleared: got=%b want=0", ovf);
        end
`ifdef COUNT_MON_STATS_EN
        n_checks++;
        if ({wrap_cnt, err_cnt} !== 32'h0) begin
            n_fail++;
            $display("FAIL stats_cleared: got=%h want=0", {wrap_cnt, err_cnt});
        end
`endif
    endtask

    task automatic test_async_reset;
        evt_ready = 1'b0;
        cyc(8'h80, 1'b0, 8'h00);
        cyc(8'h90, 1'b0, 8'h00);
        cyc(8'hA0, 1'b0, 8'h00);
        n_checks++;
        if ({evt_valid, evt_type, evt_obs} !== {1'b1, 2'd2, 8'h80}) begin
            n_fail++;
            $display("FAIL queued_before_reset: got=%h want=%h",
                     {evt_valid, evt_type, evt_obs}, {1'b1, 2'd2, 8'h80});
        end
        #2;
        reset_l = 1'b0;
        #1;
        n_checks++;
        if (head !== 19'h0) begin
            n_fail++;
            $display("FAIL async_reset_flush: got=%h want=0", head);
        end
        cyc(8'h00, 1'b0, 8'h00);
        cyc(8'h00, 1'b0, 8'h00);
        reset_l = 1'b1;
        cyc(8'h55, 1'b0, 8'h00);
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_no_compare: got=%b want=0", evt_valid);
        end
        cyc(8'h56, 1'b0, 8'h00);
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_sync_match: got=%b want=0", evt_valid);
        end
        cyc(8'h60, 1'b0, 8'h00);
        n_checks++;
        if (head !== {1'b1, 2'd2, 8'h60, 8'h57}) begin
            n_fail++;
            $display("FAIL post_reset_err: got=%h want=%h", head, {1'b1, 2'd2, 8'h60, 8'h57});
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_free_run;
        test_wrap;
        test_load;
        test_err;
        test_overflow;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/count_monitor.md
# count_monitor

Checker stage placed directly downstream of the 8-bit loadable counter. It snoops the counter's `load`/`in_data` controls and its `out_data` result, predicts each next value, and classifies every cycle as normal increment, wrap, load, or error. Classified events are queued in a small FIFO and drained over a valid/ready stream to the debug/trace logic.

## Interface
- `FIFO_DEPTH`, 4, event queue entries; power of two, ≥2
- `EMIT_LOAD`, 1, 1 = enqueue LOAD events; 0 = loads checked but not reported
- `clk` in 1: single clock, same clock as the counter
- `reset_l` in 1: asynchronous, active-low reset
- `mon_count` in 8: counter `out_data`
- `mon_load` in 1: counter `load`
- `mon_load_data` in 8: counter `in_data`
- `evt_valid` out 1: FIFO head holds an event
- `evt_ready` in 1: consumer accepts head
- `evt_type` out 2: `EVT_WRAP`=0, `EVT_LOAD`=1, `EVT_ERR`=2 (3 unused)
- `evt_obs` out 8: observed `mon_count`
- `evt_exp` out 8: predicted value
- `ovf` out 1: sticky, an event was dropped
- `ovf_clr` in 1: synchronous clear of `ovf`

## Operation
- FSM states: `SYNC`, `CHECK`.
- Reset: state `SYNC`, FIFO empty, `evt_valid`=0, `ovf`=0. `evt_type`/`evt_obs`/`evt_exp` read 0 while empty.
- `SYNC`: capture prediction only, no compare; next state `CHECK`. Used for the first cycle after reset deassertion.
- Prediction register `pred` is updated every cycle: `mon_load` ? `mon_load_data` : `mon_count`+1. Addition is mod 256, so 0xFF+1 = 0x00. `load_d` register holds the previous `mon_load`.
- `CHECK` classifies `mon_count` against `pred` each cycle. Priority, at most one event per cycle:
  - `mon_count`≠`pred` → ERR
  - else `load_d`=1 → LOAD, only if `EMIT_LOAD`=1; otherwise nothing
  - else `mon_count`=0x00 → WRAP
  - else no event
- Loading 0x00 while the count is 0xFF is LOAD, not WRAP.
- FIFO push when an event is generated; pop on `evt_valid`&&`evt_ready`.
- Full with push and no pop: event dropped, `ovf` set. Full with push and pop in the same cycle: both happen and occupancy is unchanged.
- Empty with push: no same-cycle bypass.
- `ovf` set and `ovf_clr` in the same cycle: set wins.
- FIFO entry: {type, obs, exp} = 18 bits.
- Reset asserted mid-operation flushes the FIFO and returns to `SYNC`. Queued events are lost and `ovf` is cleared.

## Timing
- Inputs sampled in cycle k form `pred`, which is compared against `mon_count` in cycle k+1.
- An event detected in cycle k+1 is written at the end of k+1. `evt_valid` rises in cycle k+2 if the FIFO was empty.
- Head outputs are registered/FIFO-read with no combinational path from `mon_*` to `evt_*`.
- `evt_valid` stays high and head fields stay stable until accepted.
- Only `evt_ready` is consumed combinationally.
- Full throughput: one push and one pop per cycle.

## Configuration
- `COUNT_MON_STATS_EN`
  - Defined: adds output ports `wrap_cnt`[15:0] and `err_cnt`[15:0]. Each counts generated WRAP/ERR events (including dropped ones), saturates at 0xFFFF, resets to 0, and is cleared by `ovf_clr`.
  - Undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Package `count_mon_pkg`:
  - `evt_type_e` enum
  - `mon_state_e` {`SYNC`, `CHECK`}
  - `CNT_W`=8
  - `evt_entry_t` packed struct
- Sub-module `count_mon_fifo`: parameterised synchronous FIFO with `push`/`pop`/`full`/`empty`, async active-low reset, and pointers of width log2(`FIFO_DEPTH`)+1.
- Top: FSM, predictor, classifier, `ovf`, optional stats.

## Test plan
- Reset release, counter free-runs 0x00→0x05, `evt_ready`=1 → no events, `evt_valid` stays 0.
- Count 0xFE, 0xFF, 0x00 → one WRAP event with obs=0x00, exp=0x00; `evt_valid` high 1 cycle after the 0x00 cycle.
- Count 0x10, assert `mon_load` with `mon_load_data`=0xA5; next cycle count=0xA5 → LOAD event with obs/exp=0xA5. With `EMIT_LOAD`=0, no event.
- Force `mon_count` 0x20 then 0x30 with no load → ERR event with obs=0x30, exp=0x21; `err_cnt`=1 with the macro defined.
- Hold `evt_ready`=0 and generate 5 WRAPs with `FIFO_DEPTH`=4 → 4 queued, `ovf`=1. Drain returns 4 events in order; pulse `ovf_clr` → `ovf`=0.
- Pull `reset_l` low asynchronously with 3 events queued → `evt_valid`=0 immediately. After release, the first cycle does not compare (no ERR even if the count jumps).
